fifo_rr_arbiter: RTL and testbench

- Shares one Fifo write port between N requesters with round-robin arbitration.
- Multi-beat packets (delimited by a last flag) are never interleaved.
- Output is registered: one cycle of latency, and the stage feeds the shared Fifo's wDatValid/wDatReady/wDat directly.
- Used in front of the shared point/bucket queues in the MSM pipeline.

---
 rtl/fifo_rr_arbiter_pkg.sv | 22 ++
 rtl/fifo_rr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin Fifo write-port arbiter.
package fifo_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } lock_state_e;

    localparam int unsigned ARB_N_DEF    = 4;
    localparam int unsigned ARB_DATA_DEF = 64;

    // Source-tag width: log2 of the requester count, never below one bit.
    function automatic int unsigned log2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Low bit of requester k's slice in the flattened payload bus.
    function automatic int unsigned dat_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin picker: first request at or above ptr, wrapping, via a double-width priority encode.
module fifo_rr_arbiter_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SRCW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SRCW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [SRCW-1:0] idx_o
);

    logic [N-1:0]   below_ptr;
    logic [2*N-1:0] dbl;
    logic           found;

    // Lower half holds requests at/above ptr, upper half the full vector for the wrap.
    always_comb begin
        below_ptr = (N'(1) << ptr_i) - N'(1);
        dbl       = {req_i, req_i & ~below_ptr};
        grant_o   = '0;
        idx_o     = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (dbl[i] && !found) begin
                found            = 1'b1;
                grant_o[i % N]   = 1'b1;
                idx_o            = SRCW'(i % N);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// N-to-1 round-robin arbiter with packet lock and a registered output feeding a Fifo write port.
// Optional: define ARB_CH0_PRIO_EN to give requester 0 fixed priority outside of a locked packet.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned N    = ARB_N_DEF,
    parameter int unsigned DATA = ARB_DATA_DEF,
    parameter int unsigned SRCW = log2_min1(N)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              clear,
    input  logic [N-1:0]      iValid,
    output logic [N-1:0]      iReady,
    input  logic [N-1:0]      iLast,
    input  logic [N*DATA-1:0] iDat,
    output logic              oValid,
    input  logic              oReady,
    output logic [DATA-1:0]   oDat,
    output logic              oLast,
    output logic [SRCW-1:0]   oSrc,
    output logic              locked
);

    logic            valid_q, valid_d;
    logic [DATA-1:0] dat_q, dat_d;
    logic            last_q, last_d;
    logic [SRCW-1:0] src_q, src_d;
    logic [SRCW-1:0] lock_src_q, lock_src_d;
    logic [SRCW-1:0] ptr_q, ptr_d;
    lock_state_e     state_q, state_d;

    logic            slot_free;
    logic [N-1:0]    rr_req, rr_grant, grant;
    logic [SRCW-1:0] rr_idx, grant_idx, ptr_inc;
    logic            accept, acc_last;
    logic [DATA-1:0] acc_dat;

    assign slot_free = !valid_q || oReady;

    // Requester 0 leaves the rotation when it has fixed priority.
    always_comb begin
        rr_req = iValid;
`ifdef ARB_CH0_PRIO_EN
        if (N > 1) rr_req[0] = 1'b0;
`endif
    end

    fifo_rr_arbiter_rr_pick #(
        .N    (N),
        .SRCW (SRCW)
    ) u_rr_pick (
        .req_i   (rr_req),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    // A locked packet owns the port; a bubble from its owner grants nobody.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (state_q == ST_PKT) begin
            if (iValid[lock_src_q]) begin
                grant[lock_src_q] = 1'b1;
                grant_idx         = lock_src_q;
            end
        end
`ifdef ARB_CH0_PRIO_EN
        else if (iValid[0]) begin
            grant[0] = 1'b1;
        end
`endif
        else begin
            grant     = rr_grant;
            grant_idx = rr_idx;
        end
    end

    assign iReady   = grant & {N{slot_free && rstN && !clear}};
    assign accept   = |iReady;
    assign acc_last = iLast[grant_idx];
    assign acc_dat  = iDat[dat_lsb(32'(grant_idx), DATA) +: DATA];

    always_comb begin
        ptr_inc = (32'(grant_idx) == N - 1) ? '0 : grant_idx + SRCW'(1);
`ifdef ARB_CH0_PRIO_EN
        if ((N > 1) && (ptr_inc == '0)) ptr_inc = SRCW'(1);
`endif
    end

    always_comb begin
        valid_d    = valid_q;
        dat_d      = dat_q;
        last_d     = last_q;
        src_d      = src_q;
        lock_src_d = lock_src_q;
        ptr_d      = ptr_q;
        state_d    = state_q;
        if (clear) begin
            valid_d = 1'b0;
            ptr_d   = '0;
            state_d = ST_IDLE;
        end else if (accept) begin
            valid_d = 1'b1;
            dat_d   = acc_dat;
            last_d  = acc_last;
            src_d   = grant_idx;
            if (acc_last) ptr_d = ptr_inc;
            unique case (state_q)
                ST_IDLE: if (!acc_last) begin
                    state_d    = ST_PKT;
                    lock_src_d = grant_idx;
                end
                ST_PKT:  if (acc_last) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            valid_q    <= 1'b0;
            dat_q      <= '0;
            last_q     <= 1'b0;
            src_q      <= '0;
            lock_src_q <= '0;
            ptr_q      <= '0;
            state_q    <= ST_IDLE;
        end else begin
            valid_q    <= valid_d;
            dat_q      <= dat_d;
            last_q     <= last_d;
            src_q      <= src_d;
            lock_src_q <= lock_src_d;
            ptr_q      <= ptr_d;
            state_q    <= state_d;
        end
    end

    assign oValid = valid_q;
    assign oDat   = dat_q;
    assign oLast  = last_q;
    assign oSrc   = src_q;
    assign locked = (state_q == ST_PKT);

    grant_onehot_a: assert property (@(posedge clk) disable iff (!rstN) $onehot0(grant));

    out_stable_a: assert property (@(posedge clk) disable iff (!rstN)
        (valid_q && !oReady && !clear) |=> ($stable(dat_q) && $stable(last_q) && $stable(src_q)));

    lock_owner_a: assert property (@(posedge clk) disable iff (!rstN)
        ((state_q == ST_PKT) && accept) |-> (grant_idx == lock_src_q));

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed self-checking bench for fifo_rr_arbiter (N=4, DATA=64) with a depth-4 Fifo model.
module tb_fifo_rr_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned DATA = 64;
    localparam int unsigned SRCW = 2;

    logic              clk = 1'b0;
    logic              rstN, clear;
    logic [N-1:0]      iValid, iReady, iLast;
    logic [N*DATA-1:0] iDat;
    logic              oValid, oReady, oLast, locked;
    logic [DATA-1:0]   oDat;
    logic [SRCW-1:0]   oSrc;

    int n_checks = 0;
    int n_errors = 0;

    logic            ready_drv = 1'b1;
    bit              fifo_mode = 1'b0;
    bit              gen_mode  = 1'b0;
    bit              rd_en     = 1'b0;
    logic [DATA-1:0] dir_dat [N];
    int unsigned     seq [N] = '{default: 0};
    logic [DATA-1:0] fq[$];
    logic [DATA-1:0] popped[$];
    int              fcnt   = 0;
    bit              f_push = 1'b0;
    bit              f_pop  = 1'b0;
    logic [DATA-1:0] f_dat  = '0;
    logic [N-1:0]    acc_n  = '0;

`ifdef ARB_CH0_PRIO_EN
    int exp_pr [4] = '{0, 0, 0, 0};
`else
    int exp_pr [4] = '{0, 2, 3, 0};
`endif
    int exp_rr [4] = '{2, 3, 2, 3};

    fifo_rr_arbiter #(.N(N), .DATA(DATA)) dut (
        .clk    (clk),
        .rstN   (rstN),
        .clear  (clear),
        .iValid (iValid),
        .iReady (iReady),
        .iLast  (iLast),
        .iDat   (iDat),
        .oValid (oValid),
        .oReady (oReady),
        .oDat   (oDat),
        .oLast  (oLast),
        .oSrc   (oSrc),
        .locked (locked)
    );

    always #5 clk = ~clk;

    // Generated payload tags each beat with its source and per-source sequence number.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            iDat[k*DATA +: DATA] = gen_mode ? ((DATA'(k) << 32) | DATA'(seq[k])) : dir_dat[k];
        end
    end

    assign oReady = fifo_mode ? (fcnt < 4) : ready_drv;

    // Handshakes are stable mid-cycle; sample them there and apply them at the next edge.
    always @(negedge clk) begin
        f_push = fifo_mode && oValid && oReady;
        f_pop  = fifo_mode && rd_en && (fcnt != 0);
        f_dat  = oDat;
        acc_n  = iValid & iReady;
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (gen_mode && acc_n[k]) seq[k] <= seq[k] + 1;
        end
        if (f_pop) popped.push_back(fq.pop_front());
        if (f_push) fq.push_back(f_dat);
        fcnt <= fcnt + (f_push ? 1 : 0) - (f_pop ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned total;

        // Reset with every requester asking
        rstN   = 1'b0;
        clear  = 1'b0;
        iValid = '1;
        iLast  = '1;
        for (int k = 0; k < N; k++) dir_dat[k] = 64'hA0 + 64'(k);
        #1;
        chk("rst_iready", 64'(iReady), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_iready", 64'(iReady), 64'h0);
            chk("rst_ovalid", 64'(oValid), 64'h0);
            chk("rst_osrc",   64'(oSrc),   64'h0);
            chk("rst_odat",   oDat,        64'h0);
            chk("rst_locked", 64'(locked), 64'h0);
        end

        // Round robin, single-beat packets, one beat per cycle
        rstN = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_iready", 64'(iReady), 64'(4'b0001 << (i % 4)));
            tick();
            chk("rr_ovalid", 64'(oValid), 64'h1);
            chk("rr_osrc",   64'(oSrc),   64'(i % 4));
            chk("rr_odat",   oDat,        64'hA0 + 64'(i % 4));
        end

        // Clear mid-stream: output dropped, pointer back to 0
        clear = 1'b1;
        #1;
        chk("clr_iready", 64'(iReady), 64'h0);
        tick();
        chk("clr_ovalid", 64'(oValid), 64'h0);
        chk("clr_locked", 64'(locked), 64'h0);
        clear = 1'b0;
        #1;
        chk("clr_ptr0", 64'(iReady), 64'h1);
        tick();
        chk("pk_pre_src", 64'(oSrc), 64'h0);

        // Three-beat packet from req1 with a two-cycle bubble
        iValid = 4'b0111;
        iLast  = 4'b0101;
        #1;
        chk("pk_b1_ready", 64'(iReady), 64'h2);
        tick();
        chk("pk_b1_src",    64'(oSrc),   64'h1);
        chk("pk_b1_last",   64'(oLast),  64'h0);
        chk("pk_b1_locked", 64'(locked), 64'h1);
        dir_dat[1] = 64'hB1;
        #1;
        chk("pk_b2_ready", 64'(iReady), 64'h2);
        tick();
        chk("pk_b2_dat",    oDat,        64'hB1);
        chk("pk_b2_locked", 64'(locked), 64'h1);
        iValid = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("pk_gap_ready", 64'(iReady), 64'h0);
            tick();
            chk("pk_gap_valid",  64'(oValid), 64'h0);
            chk("pk_gap_locked", 64'(locked), 64'h1);
        end
        iValid     = 4'b0111;
        iLast      = 4'b0111;
        dir_dat[1] = 64'hC1;
        #1;
        chk("pk_b3_ready", 64'(iReady), 64'h2);
        tick();
        chk("pk_b3_src",    64'(oSrc),   64'h1);
        chk("pk_b3_dat",    oDat,        64'hC1);
        chk("pk_b3_last",   64'(oLast),  64'h1);
        chk("pk_b3_locked", 64'(locked), 64'h0);
        dir_dat[1] = 64'hA1;
        #1;
        chk("pk_rot2_ready", 64'(iReady), 64'h4);
        tick();
        chk("pk_rot2_src", 64'(oSrc), 64'h2);
        #1;
        chk("pk_rot0_ready", 64'(iReady), 64'h1);
        tick();
        chk("pk_rot0_src", 64'(oSrc), 64'h0);

        // Backpressure holds the output stage
        ready_drv = 1'b0;
        iValid    = '1;
        iLast     = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_iready", 64'(iReady), 64'h0);
            tick();
            chk("bp_ovalid", 64'(oValid), 64'h1);
            chk("bp_osrc",   64'(oSrc),   64'h0);
            chk("bp_odat",   oDat,        64'hA0);
        end
        ready_drv = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(iReady), 64'h2);
        tick();
        chk("bp_rel_src", 64'(oSrc), 64'h1);
        chk("bp_rel_dat", oDat,      64'hA1);

        // Depth-4 Fifo, no reads: 4 beats stored, a 5th held in the output stage
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        fifo_mode = 1'b1;
        gen_mode  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("fifo_cnt",        64'(fcnt),   64'h4);
        chk("fifo_full_ready", 64'(iReady), 64'h0);
        chk("fifo_hold_valid", 64'(oValid), 64'h1);
        chk("fifo_hold_src",   64'(oSrc),   64'h0);
        chk("fifo_hold_dat",   oDat,        64'h1);
        total = seq[0] + seq[1] + seq[2] + seq[3];
        chk("fifo_accepted", 64'(total), 64'h5);

        // Reads resume the flow; then drain and check per-source order
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        iValid = '0;
        for (int i = 0; i < 10; i++) tick();
        total = seq[0] + seq[1] + seq[2] + seq[3];
        chk("fifo_drained",  64'(fcnt),          64'h0);
        chk("fifo_popcount", 64'(popped.size()), 64'(total));
        chk("fifo_progress", 64'(popped.size() > 12), 64'h1);
        for (int i = 0; i < popped.size(); i++) begin
            chk("fifo_order", popped[i], (64'(i % 4) << 32) | 64'(i / 4));
        end

        // Requester 0 against 2/3, then 2/3 alone
        fifo_mode = 1'b0;
        gen_mode  = 1'b0;
        rd_en     = 1'b0;
        ready_drv = 1'b1;
        clear     = 1'b1;
        tick();
        clear  = 1'b0;
        iValid = 4'b1101;
        iLast  = '1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pr_osrc",   64'(oSrc),   64'(exp_pr[i]));
            chk("pr_ovalid", 64'(oValid), 64'h1);
        end
        iValid = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pr_rr_osrc", 64'(oSrc), 64'(exp_rr[i]));
            chk("pr_rr_dat",  oDat,      64'hA0 + 64'(exp_rr[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
